// File: rtl/battle_engine_param.sv
// Turn-based battle resolver: turn FSM, valid/ready attack handshakes, LFSR rolls, saturating HP/ammo.
// Latency: handshake edge -> RESOLVE; HP/ammo/result_* update on the following edge (result_valid 1-cycle pulse).
// Backpressure: player_ready only in P_TURN, enemy_ready only in E_TURN; requests are held off otherwise.
// Ports: clk/rst; collision_detected level enables the battle; player_*/enemy_* attack handshakes;
//        force_* deterministic roll override; HP/ammo status; result_* pulse; sticky win flags.
module battle_engine_param #(
  parameter int          HP_W           = 8,
  parameter int          AMMO_W         = 5,
  parameter int          PLAYER_HP_INIT = 100,
  parameter int          ENEMY_HP_MIN   = 50,
  parameter int          ENEMY_HP_MAX   = 100,
  parameter int          BAT_AMMO       = 3,
  parameter int          SWORD_AMMO     = 2,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              collision_detected,
  input  logic              player_valid,
  input  logic [1:0]        player_choice,
  output logic              player_ready,
  input  logic              enemy_valid,
  input  logic [1:0]        enemy_choice,
  output logic              enemy_ready,
  input  logic              force_en,
  input  logic [3:0]        force_acc,
  input  logic [4:0]        force_var,
  output logic [HP_W-1:0]   player_HP,
  output logic [HP_W-1:0]   enemy_HP,
  output logic [AMMO_W-1:0] player_remained_bat,
  output logic [AMMO_W-1:0] player_remained_sword,
  output logic [AMMO_W-1:0] enemy_remained_bat,
  output logic [AMMO_W-1:0] enemy_remained_sword,
  output logic              result_valid,
  output logic              result_hit,
  output logic [HP_W-1:0]   result_damage,
  output logic              player_win,
  output logic              enemy_win
);

  localparam int EN_RANGE = ENEMY_HP_MAX - ENEMY_HP_MIN + 1;

  typedef enum logic [2:0] {IDLE, INIT, P_TURN, E_TURN, RESOLVE, DONE} state_t;

  state_t      state, state_n;
  logic        coll_q;
  logic [15:0] lfsr, lfsr_n;
  logic        attacker;      // 0 = player attacks enemy, 1 = enemy attacks player
  logic [1:0]  choice_q;

  logic [3:0]      roll, acc;
  logic [4:0]      varf;
  logic [5:0]      base, var_amt, rem, dmg_raw;
  logic [1:0]      thresh;
  logic            is_bat, is_sword, no_ammo, hit;
  logic [HP_W-1:0] dmg, tgt_hp, tgt_hp_new, init_enemy_hp;
  logic            abort;

  // Galois LFSR, right-shifting; free-runs in every state.
  assign lfsr_n = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

  assign roll = force_en ? force_acc : lfsr[3:0];
  assign varf = force_en ? force_var : lfsr[8:4];
  assign acc  = (roll >= 4'd10) ? roll - 4'd10 : roll;

  assign init_enemy_hp = force_en ? HP_W'(ENEMY_HP_MIN)
                                  : HP_W'(ENEMY_HP_MIN + (int'(lfsr[15:8]) % EN_RANGE));

  always_comb begin
    thresh  = 2'd0;
    base    = 6'd10;
    var_amt = 6'd2;
    case (choice_q)
      2'b00: begin thresh = 2'd0; base = 6'd10; var_amt = 6'd2; end
      2'b01: begin thresh = 2'd1; base = 6'd20; var_amt = 6'd4; end
      2'b10: begin thresh = 2'd2; base = 6'd30; var_amt = 6'd6; end
      default: begin thresh = 2'd3; base = 6'd40; var_amt = 6'd8; end
    endcase
  end

  assign is_bat   = (choice_q == 2'b10);
  assign is_sword = (choice_q == 2'b11);
  // An empty weapon still consumes the turn but can never land.
  assign no_ammo  = attacker ? ((is_bat && enemy_remained_bat == '0) || (is_sword && enemy_remained_sword == '0))
                             : ((is_bat && player_remained_bat == '0) || (is_sword && player_remained_sword == '0));
  assign hit      = !no_ammo && (acc > {2'b00, thresh});
  assign rem      = {1'b0, varf} % (var_amt + var_amt + 6'd1);
  assign dmg_raw  = base - var_amt + rem;
  assign dmg      = hit ? HP_W'(dmg_raw) : '0;

  assign tgt_hp     = attacker ? player_HP : enemy_HP;
  assign tgt_hp_new = (tgt_hp < dmg) ? '0 : tgt_hp - dmg;

  // Losing the collision aborts any battle in progress.
  assign abort = (state != IDLE) && !collision_detected;

  assign player_ready = (state == P_TURN);
  assign enemy_ready  = (state == E_TURN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (collision_detected && !coll_q) state_n = INIT;
      INIT:    state_n = P_TURN;
      P_TURN:  if (player_valid) state_n = RESOLVE;
      E_TURN:  if (enemy_valid) state_n = RESOLVE;
      RESOLVE: begin
        if (tgt_hp_new == '0) state_n = DONE;
        else                  state_n = attacker ? P_TURN : E_TURN;
      end
      DONE:    state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_q                <= 1'b0;
      lfsr                  <= LFSR_SEED;
      attacker              <= 1'b0;
      choice_q              <= 2'b00;
      player_HP             <= HP_W'(PLAYER_HP_INIT);
      enemy_HP              <= HP_W'(ENEMY_HP_MAX);
      player_remained_bat   <= AMMO_W'(BAT_AMMO);
      player_remained_sword <= AMMO_W'(SWORD_AMMO);
      enemy_remained_bat    <= AMMO_W'(BAT_AMMO);
      enemy_remained_sword  <= AMMO_W'(SWORD_AMMO);
      result_valid          <= 1'b0;
      result_hit            <= 1'b0;
      result_damage         <= '0;
      player_win            <= 1'b0;
      enemy_win             <= 1'b0;
    end else begin
      coll_q       <= collision_detected;
      lfsr         <= lfsr_n;
      result_valid <= 1'b0;
      if (abort) begin
        player_win <= 1'b0;
        enemy_win  <= 1'b0;
      end else begin
        case (state)
          INIT: begin
            player_HP             <= HP_W'(PLAYER_HP_INIT);
            enemy_HP              <= init_enemy_hp;
            player_remained_bat   <= AMMO_W'(BAT_AMMO);
            player_remained_sword <= AMMO_W'(SWORD_AMMO);
            enemy_remained_bat    <= AMMO_W'(BAT_AMMO);
            enemy_remained_sword  <= AMMO_W'(SWORD_AMMO);
          end
          P_TURN: if (player_valid) begin
            attacker <= 1'b0;
            choice_q <= player_choice;
          end
          E_TURN: if (enemy_valid) begin
            attacker <= 1'b1;
            choice_q <= enemy_choice;
          end
          RESOLVE: begin
            result_valid  <= 1'b1;
            result_hit    <= hit;
            result_damage <= dmg;
            if (attacker) begin
              player_HP <= tgt_hp_new;
              if (is_bat && enemy_remained_bat != '0)     enemy_remained_bat   <= enemy_remained_bat - 1'b1;
              if (is_sword && enemy_remained_sword != '0) enemy_remained_sword <= enemy_remained_sword - 1'b1;
              if (tgt_hp_new == '0) enemy_win <= 1'b1;
            end else begin
              enemy_HP <= tgt_hp_new;
              if (is_bat && player_remained_bat != '0)     player_remained_bat   <= player_remained_bat - 1'b1;
              if (is_sword && player_remained_sword != '0) player_remained_sword <= player_remained_sword - 1'b1;
              if (tgt_hp_new == '0) player_win <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_battle_engine_param.sv
// Directed bench for battle_engine_param with hand-computed expectations.
module tb_battle_engine_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       collision_detected;
  logic       player_valid;
  logic [1:0] player_choice;
  logic       player_ready;
  logic       enemy_valid;
  logic [1:0] enemy_choice;
  logic       enemy_ready;
  logic       force_en;
  logic [3:0] force_acc;
  logic [4:0] force_var;
  logic [7:0] player_HP, enemy_HP, result_damage;
  logic [4:0] player_remained_bat, player_remained_sword;
  logic [4:0] enemy_remained_bat, enemy_remained_sword;
  logic       result_valid, result_hit, player_win, enemy_win;

  int n_cmp = 0;
  int n_err = 0;

  battle_engine_param dut (
    .clk(clk), .rst(rst), .collision_detected(collision_detected),
    .player_valid(player_valid), .player_choice(player_choice), .player_ready(player_ready),
    .enemy_valid(enemy_valid), .enemy_choice(enemy_choice), .enemy_ready(enemy_ready),
    .force_en(force_en), .force_acc(force_acc), .force_var(force_var),
    .player_HP(player_HP), .enemy_HP(enemy_HP),
    .player_remained_bat(player_remained_bat), .player_remained_sword(player_remained_sword),
    .enemy_remained_bat(enemy_remained_bat), .enemy_remained_sword(enemy_remained_sword),
    .result_valid(result_valid), .result_hit(result_hit), .result_damage(result_damage),
    .player_win(player_win), .enemy_win(enemy_win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake edge then resolve edge; returns just after the result edge.
  task automatic player_attack(input logic [1:0] c);
    player_valid  = 1'b1;
    player_choice = c;
    tick();
    player_valid  = 1'b0;
    tick();
  endtask

  task automatic enemy_attack(input logic [1:0] c);
    enemy_valid  = 1'b1;
    enemy_choice = c;
    tick();
    enemy_valid  = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; collision_detected = 1'b0;
    player_valid = 1'b0; player_choice = 2'b00;
    enemy_valid = 1'b0; enemy_choice = 2'b00;
    force_en = 1'b0; force_acc = 4'd0; force_var = 5'd0;
    #12;
    // Reset state
    chk("rst_player_hp", player_HP, 100);
    chk("rst_enemy_hp", enemy_HP, 100);
    chk("rst_ammo", {player_remained_bat, player_remained_sword, enemy_remained_bat, enemy_remained_sword},
        {5'd3, 5'd2, 5'd3, 5'd2});
    chk("rst_ready", {player_ready, enemy_ready}, 0);
    chk("rst_pulse_win", {result_valid, player_win, enemy_win}, 0);
    rst = 1'b0;
    tick();

    // T1: battle start with forced rolls
    collision_detected = 1'b1; force_en = 1'b1;
    tick();
    chk("t1_ready_init", player_ready, 0);
    tick();
    chk("t1_ready_pturn", player_ready, 1);
    chk("t1_hp", {player_HP, enemy_HP}, {8'd100, 8'd50});

    // T2: player punch, acc 9, var 2 -> 10 damage
    force_acc = 4'd9; force_var = 5'd2;
    player_valid = 1'b1; player_choice = 2'b00;
    tick();
    player_valid = 1'b0;
    chk("t2_latency_hp", enemy_HP, 50);
    chk("t2_latency_pulse", result_valid, 0);
    tick();
    chk("t2_result", {result_valid, result_hit, result_damage}, {1'b1, 1'b1, 8'd10});
    chk("t2_enemy_hp", enemy_HP, 40);
    chk("t2_enemy_ready", {enemy_ready, player_ready}, 2'b10);
    tick();
    chk("t2_pulse_1cyc", result_valid, 0);

    // T3: enemy punch with acc 0 misses
    force_acc = 4'd0;
    enemy_attack(2'b00);
    chk("t3_result", {result_valid, result_hit, result_damage}, {1'b1, 1'b0, 8'd0});
    chk("t3_player_hp", player_HP, 100);
    chk("t3_player_ready", player_ready, 1);

    // Enemy request in the player's turn is ignored
    enemy_valid = 1'b1;
    tick();
    chk("t4_ignore_enemy", {player_ready, enemy_ready}, 2'b10);

    // T4: bat x4 (miss rolls), both valids high on the first
    for (int i = 1; i <= 4; i++) begin
      force_acc = (i == 4) ? 4'd9 : 4'd0;
      player_attack(2'b10);
      enemy_valid = 1'b0;
      chk("t4_bat_ammo", player_remained_bat, (i >= 3) ? 0 : 3 - i);
      chk("t4_bat_dmg", {result_valid, result_hit, result_damage}, {1'b1, 1'b0, 8'd0});
      force_acc = 4'd0;
      enemy_attack(2'b00);
    end
    chk("t4_enemy_hp", enemy_HP, 40);
    chk("t4_enemy_bat", enemy_remained_bat, 3);

    // T5: abort holds HP, then fresh battle to a win
    collision_detected = 1'b0;
    tick();
    chk("t5_abort_idle", {player_ready, enemy_ready}, 0);
    chk("t5_abort_hold", enemy_HP, 40);
    collision_detected = 1'b1;
    tick();
    tick();
    chk("t5_restart", {player_ready, player_HP, enemy_HP, player_remained_bat}, {1'b1, 8'd100, 8'd50, 5'd3});
    force_acc = 4'd9; force_var = 5'd16;
    player_attack(2'b11);
    chk("t5_sword", {result_damage, enemy_HP, player_remained_sword}, {8'd48, 8'd2, 5'd1});
    force_acc = 4'd13; force_var = 5'd31;   // roll 13 -> acc 3; 31 mod 9 = 4 -> 20
    enemy_attack(2'b01);
    chk("t5_enemy_kick", {result_hit, result_damage, player_HP}, {1'b1, 8'd20, 8'd80});
    force_acc = 4'd9; force_var = 5'd0;
    player_attack(2'b00);
    chk("t5_saturate", {result_damage, enemy_HP}, {8'd8, 8'd0});
    chk("t5_win", {player_win, enemy_win, player_ready, enemy_ready}, 4'b1000);
    tick();
    chk("t5_win_sticky", player_win, 1);
    collision_detected = 1'b0;
    tick();
    chk("t5_win_clear", {player_win, enemy_HP}, {1'b0, 8'd0});

    // T6: async reset in E_TURN
    collision_detected = 1'b1;
    tick();
    tick();
    force_acc = 4'd0;
    player_attack(2'b01);
    chk("t6_in_eturn", enemy_ready, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_hp", {player_HP, enemy_HP}, {8'd100, 8'd100});
    chk("t6_rst_ready", {player_ready, enemy_ready, result_valid}, 0);
    #1;
    rst = 1'b0;
    collision_detected = 1'b0;
    tick();
    collision_detected = 1'b1;
    force_en = 1'b0;
    tick();
    tick();
    chk("t6_restart_ready", player_ready, 1);
    chk("t6_random_hp_range", (enemy_HP >= 8'd50 && enemy_HP <= 8'd100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
